// File: rtl/special_purpose_register_bank.sv
// Special-purpose register bank: zero/address/base/index/SP/BP/data registers, two registered
// read ports, one write port and a bounds-checked stack-pointer unit. Optional forwarding: SPR_BYPASS_EN.
module special_purpose_register_bank #(
  parameter int unsigned              DATA_WIDTH  = 16,
  parameter int unsigned              REG_COUNT   = 8,
  parameter int unsigned              ADDR_WIDTH  = 3,
  parameter int unsigned              SP_INDEX    = 4,
  parameter logic [DATA_WIDTH-1:0]    STACK_TOP   = '1,
  parameter logic [DATA_WIDTH-1:0]    STACK_LIMIT = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [1:0]            sp_op,
  input  logic                  clear_flags,
  output logic [DATA_WIDTH-1:0] sp_value,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  typedef enum logic [1:0] {
    SP_NONE  = 2'b00,
    SP_PUSH  = 2'b01,
    SP_POP   = 2'b10,
    SP_NONE2 = 2'b11
  } sp_op_e;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t              regs_q [REG_COUNT];
  word_t              regs_d [REG_COUNT];
  word_t              read_data1_q, read_data1_d;
  word_t              read_data2_q, read_data2_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic [REG_COUNT-1:0] wr_hit;
  logic               sp_written;
  sp_op_e             sp_cmd;
  word_t              sp_q;
  word_t              sp_next;
  logic               push_at_limit;
  logic               pop_at_top;

  // Write decode: index 0 never matches, and indices >= REG_COUNT have no decoder output.
  always_comb begin
    wr_hit = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      wr_hit[i] = write_en && (write_addr == ADDR_WIDTH'(i));
    end
  end

  assign sp_written = wr_hit[SP_INDEX];
  assign sp_cmd     = sp_op_e'(sp_op);
  assign sp_q       = regs_q[SP_INDEX];

  // Stack-pointer unit. An explicit write to SP suppresses the operation and its flags.
  // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    sp_next       = sp_q;
    push_at_limit = 1'b0;
    pop_at_top    = 1'b0;
    if (!sp_written) begin
      unique case (sp_cmd)
        SP_PUSH: begin
          if (sp_q == STACK_LIMIT) push_at_limit = 1'b1;
          else                     sp_next = sp_q - 1'b1;
        end
        SP_POP: begin
          if (sp_q == STACK_TOP) pop_at_top = 1'b1;
          else                   sp_next = sp_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state register array: explicit writes first, then the SP unit when SP was not written.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit[i]) regs_d[i] = write_data;
    end
    if (!sp_written) regs_d[SP_INDEX] = sp_next;
    regs_d[0] = '0;
  end

  // Sticky flags: a new violation wins over a same-cycle clear.
  always_comb begin
    overflow_d  = (overflow_q  & ~clear_flags) | push_at_limit;
    underflow_d = (underflow_q & ~clear_flags) | pop_at_top;
  end

  // Read mux. With forwarding the post-edge contents are returned, which covers both the
  // same-index write and the effective SP update.
  function automatic word_t read_word(input logic [ADDR_WIDTH-1:0] addr,
                                      input word_t arr [REG_COUNT]);
    word_t val;
    val = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (addr == ADDR_WIDTH'(i)) val = arr[i];
    end
    return val;
  endfunction

  always_comb begin
    read_data1_d = '0;
    read_data2_d = '0;
    if (read_en) begin
`ifdef SPR_BYPASS_EN
      read_data1_d = read_word(read_addr1, regs_d);
      read_data2_d = read_word(read_addr2, regs_d);
`else
      read_data1_d = read_word(read_addr1, regs_q);
      read_data2_d = read_word(read_addr2, regs_q);
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the register array is reset explicitly; it is a handful of flops, not a RAM macro.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? STACK_TOP : '0;
      end
      read_data1_q <= '0;
      read_data2_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign read_data1      = read_data1_q;
  assign read_data2      = read_data2_q;
  assign sp_value        = sp_q;
  assign stack_overflow  = overflow_q;
  assign stack_underflow = underflow_q;

endmodule

// File: tb/tb_special_purpose_register_bank.sv
// Directed bench for special_purpose_register_bank: default 8-register instance plus a
// 6-register instance sharing the same stimulus for the out-of-range write case.
module tb_special_purpose_register_bank;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          read_en;
  logic [AW-1:0] read_addr1, read_addr2;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [1:0]    sp_op;
  logic          clear_flags;

  logic [DW-1:0] rd1, rd2, sp_value;
  logic          ovf, udf;
  logic [DW-1:0] rd1_6, rd2_6, sp_value_6;
  logic          ovf_6, udf_6;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  special_purpose_register_bank u_dut (
    .clock(clock), .reset(reset), .read_en(read_en),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1), .read_data2(rd2),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .sp_op(sp_op), .clear_flags(clear_flags),
    .sp_value(sp_value), .stack_overflow(ovf), .stack_underflow(udf)
  );

  special_purpose_register_bank #(.REG_COUNT(6)) u_dut6 (
    .clock(clock), .reset(reset), .read_en(read_en),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_6), .read_data2(rd2_6),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .sp_op(sp_op), .clear_flags(clear_flags),
    .sp_value(sp_value_6), .stack_overflow(ovf_6), .stack_underflow(udf_6)
  );

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs are changed only after this returns.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    read_en = 1'b0; read_addr1 = '0; read_addr2 = '0;
    write_en = 1'b0; write_addr = '0; write_data = '0;
    sp_op = 2'b00; clear_flags = 1'b0;
  endtask

  logic [DW-1:0] exp_fwd;

  initial begin
    reset = 1'b0;
    idle();
    step();
    check("reset_rd1", rd1, 16'h0000);
    check("reset_sp", sp_value, 16'hFFFF);

    // Reads after reset: SP index 4 and plain register 1.
    reset = 1'b1;
    read_en = 1'b1; read_addr1 = 3'd4; read_addr2 = 3'd1;
    step();
    check("post_reset_rd1", rd1, 16'hFFFF);
    check("post_reset_rd2", rd2, 16'h0000);
    check("post_reset_sp", sp_value, 16'hFFFF);
    check("post_reset_ovf", {15'b0, ovf}, 16'h0000);
    check("post_reset_udf", {15'b0, udf}, 16'h0000);

    // Zero register discards writes; index 6 holds data; read_en=0 clears outputs.
    idle();
    write_en = 1'b1; write_addr = 3'd0; write_data = 16'h1234;
    step();
    write_addr = 3'd6; write_data = 16'hABCD;
    step();
    idle();
    read_en = 1'b1; read_addr1 = 3'd0; read_addr2 = 3'd6;
    step();
    check("zero_reg_rd", rd1, 16'h0000);
    check("idx6_rd", rd2, 16'hABCD);
    read_en = 1'b0;
    step();
    check("rd_disabled_1", rd1, 16'h0000);
    check("rd_disabled_2", rd2, 16'h0000);

    // Pop at top sets underflow; three pushes step down; clear drops the flag.
    idle();
    sp_op = 2'b10;
    step();
    check("pop_top_sp", sp_value, 16'hFFFF);
    check("pop_top_udf", {15'b0, udf}, 16'h0001);
    sp_op = 2'b01;
    step(); step(); step();
    check("push3_sp", sp_value, 16'hFFFC);
    check("push3_udf_sticky", {15'b0, udf}, 16'h0001);
    sp_op = 2'b00; clear_flags = 1'b1;
    step();
    check("clear_udf", {15'b0, udf}, 16'h0000);

    // Push down to the limit, then overflow; set wins over clear.
    idle();
    write_en = 1'b1; write_addr = 3'd4; write_data = 16'h0001;
    step();
    idle();
    sp_op = 2'b01;
    step();
    check("push_to_limit_sp", sp_value, 16'h0000);
    check("push_to_limit_ovf", {15'b0, ovf}, 16'h0000);
    step();
    check("push_at_limit_sp", sp_value, 16'h0000);
    check("push_at_limit_ovf", {15'b0, ovf}, 16'h0001);
    clear_flags = 1'b1;
    step();
    check("set_beats_clear", {15'b0, ovf}, 16'h0001);
    sp_op = 2'b00;
    step();
    check("clear_ovf", {15'b0, ovf}, 16'h0000);

    // Explicit SP write beats a same-cycle push.
    idle();
    write_en = 1'b1; write_addr = 3'd4; write_data = 16'h0050; sp_op = 2'b01;
    step();
    check("sp_write_wins", sp_value, 16'h0050);
    check("sp_write_no_ovf", {15'b0, ovf}, 16'h0000);
    check("sp_write_no_udf", {15'b0, udf}, 16'h0000);

    // Out-of-range writes on the 6-register instance leave its registers alone.
    idle();
    write_en = 1'b1; write_addr = 3'd5; write_data = 16'h5555;
    step();
    write_addr = 3'd7; write_data = 16'hDEAD;
    step();
    write_addr = 3'd6; write_data = 16'hBEEF;
    step();
    idle();
    read_en = 1'b1; read_addr1 = 3'd5; read_addr2 = 3'd7;
    step();
    check("r6_idx5_kept", rd1_6, 16'h5555);
    check("r6_idx7_zero", rd2_6, 16'h0000);
    check("r8_idx7_written", rd2, 16'hDEAD);
    read_addr1 = 3'd6; read_addr2 = 3'd4;
    step();
    check("r6_idx6_zero", rd1_6, 16'h0000);
    check("r6_sp_kept", rd2_6, 16'h0050);
    check("r8_idx6_written", rd1, 16'hBEEF);

    // Read-during-write to the same index, and SP read with an effective push.
    idle();
    write_en = 1'b1; write_addr = 3'd2; write_data = 16'h00AA;
    read_en = 1'b1; read_addr1 = 3'd2; read_addr2 = 3'd4; sp_op = 2'b01;
    step();
`ifdef SPR_BYPASS_EN
    exp_fwd = 16'h00AA;
    check("rdw_sp", rd2, 16'h004F);
`else
    exp_fwd = 16'h0000;
    check("rdw_sp", rd2, 16'h0050);
`endif
    check("rdw_idx2", rd1, exp_fwd);
    idle();
    read_en = 1'b1; read_addr1 = 3'd2; read_addr2 = 3'd4;
    step();
    check("idx2_after", rd1, 16'h00AA);
    check("sp_after_push", rd2, 16'h004F);

    // Reset mid-operation discards the pending write and sp_op.
    reset = 1'b0;
    write_en = 1'b1; write_addr = 3'd3; write_data = 16'h7777; sp_op = 2'b01;
    step();
    check("mid_reset_sp", sp_value, 16'hFFFF);
    check("mid_reset_rd1", rd1, 16'h0000);
    reset = 1'b1;
    idle();
    read_en = 1'b1; read_addr1 = 3'd3; read_addr2 = 3'd2;
    step();
    check("mid_reset_idx3", rd1, 16'h0000);
    check("mid_reset_idx2", rd2, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/special_purpose_register_bank.md
# special_purpose_register_bank

Parametrised special-purpose register bank for the datapath: a zero register, address, base, index, stack-pointer, base-pointer and data registers plus spare slots. It provides two registered read ports and one write port. A built-in stack-pointer unit handles push/pop adjustment with bounds checking. It sits beside the general-purpose register file and feeds address generation and the stack/memory stage.

## Interface
- DATA_WIDTH, 16: width of every register and data port.
- REG_COUNT, 8: number of registers; index 0 is the zero register.
- ADDR_WIDTH, 3: width of address ports; must satisfy 2^ADDR_WIDTH >= REG_COUNT.
- SP_INDEX, 4: register index of the stack pointer.
- STACK_TOP, all ones: reset value of SP; highest legal SP.
- STACK_LIMIT, 0: lowest legal SP.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low.
- read_en  in  1  sample both read ports this edge.
- read_addr1, read_addr2  in  ADDR_WIDTH  read indices.
- read_data1, read_data2  out  DATA_WIDTH  registered read results.
- write_en  in  1  write request.
- write_addr  in  ADDR_WIDTH  write index.
- write_data  in  DATA_WIDTH  write value.
- sp_op  in  2  stack-pointer operation: 00 none, 01 push (SP-1), 10 pop (SP+1), 11 none.
- clear_flags  in  1  clear sticky stack flags.
- sp_value  out  DATA_WIDTH  current SP, direct from register.
- stack_overflow  out  1  sticky: a push was attempted at STACK_LIMIT.
- stack_underflow  out  1  sticky: a pop was attempted at STACK_TOP.

## Operation
- Reset (reset==0 at edge):
  - All registers go to 0, except SP, which goes to STACK_TOP.
  - read_data1/2 go to 0; both flags go to 0.
  - sp_value shows STACK_TOP from the following cycle.
  - Reset overrides every other input in that cycle.
- Register 0:
  - Always reads 0.
  - Writes to it are discarded silently.
- Writes: when write_en=1 and 0 < write_addr < REG_COUNT, the register takes write_data at the edge. Addresses >= REG_COUNT are ignored.
- Reads:
  - When read_en=1, read_dataN registers the addressed value at the edge.
  - An address >= REG_COUNT yields 0.
  - When read_en=0, both outputs load 0.
- Stack pointer:
  - push at SP > STACK_LIMIT: SP <= SP-1.
  - push at SP == STACK_LIMIT: SP unchanged; stack_overflow <= 1.
  - pop at SP < STACK_TOP: SP <= SP+1.
  - pop at SP == STACK_TOP: SP unchanged; stack_underflow <= 1.
  - Arithmetic is modulo 2^DATA_WIDTH, but the bounds checks prevent wrap-around.
- Simultaneous events:
  - A write to SP_INDEX and a non-zero sp_op in the same cycle: the explicit write wins, sp_op is ignored, and no flag is set.
  - clear_flags and a new violation in the same cycle: the flag ends at 1 (set wins).
- A write whose value is out of bounds for SP is accepted unchecked.

## Timing
- Write, SP update and flag update all take effect at the rising edge; they are visible on sp_value and the register array in the next cycle.
- Read latency is 1 cycle: the address is presented in cycle N and data is valid in cycle N+1, held until the next edge.
- Read-during-write to the same index in the same cycle is governed by Configuration.
- Reset mid-operation: any pending write or sp_op in the reset cycle is discarded.

## Configuration
- SPR_BYPASS_EN defined (forwarding on):
  - A read in the same cycle as a write to the same non-zero valid index returns write_data.
  - A read of SP_INDEX in a cycle with an effective sp_op returns the post-update SP.
- SPR_BYPASS_EN undefined: same-cycle reads return the pre-edge register contents.

## Test plan
- Reset with reset=0 for one edge. Then read_en=1 with addresses 4 and 1. Required: read_data1=16'hFFFF, read_data2=0, sp_value=16'hFFFF, both flags 0.
- Write 16'h1234 to index 0 and 16'hABCD to index 6, then read both next cycle. Required: read_data1=0, read_data2=16'hABCD; read_en=0 on the following cycle drives both outputs to 0.
- From reset, pop once. Required: SP stays 16'hFFFF and stack_underflow=1. Then push 3 times: SP=16'hFFFC, and the flag stays set until clear_flags.
- Write SP=16'h0001, then push twice. Required: SP=16'h0000 after the first push. The second push leaves SP at 0 and sets stack_overflow=1. A push with clear_flags asserted in the same cycle leaves stack_overflow=1.
- Write 16'h0050 to SP_INDEX with sp_op=push in the same cycle. Required: SP=16'h0050 and no flag change. Out-of-range write_addr=7 with REG_COUNT=6 changes no register.
- Same-cycle write of 16'h00AA to index 2 with a read of index 2. Required: read_data=16'h00AA with SPR_BYPASS_EN, and the old value 0 without it.
